// File: rtl/dqt_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dqt_parser                                                      |
// | Purpose  : Finds the FFDB segment in a JPEG byte stream and captures the   |
// |            8-bit luma/chroma quantisation tables. Define                   |
// |            DQT_PARSER_RECIP_EN to add the serial reciprocal divider.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dqt_parser #(
    parameter int MCU_SIZE      = 8,
    parameter int QUAN_BITWIDTH = 12
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [7:0]                                            s_data,
    input  logic                                                  s_valid,
    output logic                                                  s_ready,
    output logic [MCU_SIZE-1:0][MCU_SIZE-1:0][7:0]                y_table,
    output logic [MCU_SIZE-1:0][MCU_SIZE-1:0][7:0]                uv_table,
    output logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]  y_recip,
    output logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]  uv_recip,
    output logic                                                  y_valid,
    output logic                                                  uv_valid,
    output logic                                                  done,
    output logic                                                  err,
    output logic [1:0]                                            err_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FF1   = 3'd1;
    localparam logic [2:0] S_LEN_H = 3'd2;
    localparam logic [2:0] S_LEN_L = 3'd3;
    localparam logic [2:0] S_PQTQ  = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_RECIP = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]                            r_state;
    logic [7:0]                            r_len_h;
    logic [15:0]                           r_rem;
    logic                                  r_tq;
    logic [5:0]                            r_idx;
    logic [1:0]                            r_loaded;
    logic [MCU_SIZE-1:0][MCU_SIZE-1:0][7:0] r_y_table;
    logic [MCU_SIZE-1:0][MCU_SIZE-1:0][7:0] r_uv_table;
    logic                                  r_y_valid;
    logic                                  r_uv_valid;
    logic                                  r_done;
    logic                                  r_err;
    logic [1:0]                            r_err_code;

    logic        w_acc;
    logic [15:0] w_lq;
    logic [15:0] w_lq_m2;
    logic        w_len_bad;
    logic        w_pqtq_bad;

    assign s_ready    = (r_state != S_RECIP) && (r_state != S_DONE);
    assign w_acc      = s_valid && s_ready;
    assign w_lq       = {r_len_h, s_data};
    assign w_lq_m2    = w_lq - 16'd2;
    // Lq must carry at least one table and be a whole number of 65-byte tables
    assign w_len_bad  = (w_lq < 16'd3) || ((w_lq_m2 % 16'd65) != 16'd0);
    assign w_pqtq_bad = (s_data[7:4] != 4'd0) || (s_data[3:0] > 4'd1);

`ifdef DQT_PARSER_RECIP_EN
    localparam int c_BIT_W = $clog2(QUAN_BITWIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(QUAN_BITWIDTH);

    logic                                                  r_div_tbl;
    logic [5:0]                                            r_div_idx;
    logic [c_BIT_W-1:0]                                    r_div_bit;
    logic [8:0]                                            r_div_rem;
    logic [QUAN_BITWIDTH:0]                                r_div_quo;
    logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]  r_y_recip;
    logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]  r_uv_recip;

    logic [7:0]               w_div_q;
    logic [8:0]               w_div_shift;
    logic                     w_div_ge;
    logic [8:0]               w_div_rem_nx;
    logic [QUAN_BITWIDTH:0]   w_div_quo_nx;
    logic [QUAN_BITWIDTH-1:0] w_div_res;

    // Restoring division of (1<<QUAN_BITWIDTH) by q: the dividend's only set bit is its MSB
    assign w_div_q      = r_div_tbl ? r_uv_table[r_div_idx[5:3]][r_div_idx[2:0]]
                                    : r_y_table[r_div_idx[5:3]][r_div_idx[2:0]];
    assign w_div_shift  = {r_div_rem[7:0], (r_div_bit == '0)};
    assign w_div_ge     = w_div_shift >= {1'b0, w_div_q};
    assign w_div_rem_nx = w_div_ge ? (w_div_shift - {1'b0, w_div_q}) : w_div_shift;
    assign w_div_quo_nx = {r_div_quo[QUAN_BITWIDTH-1:0], w_div_ge};
    assign w_div_res    = w_div_quo_nx[QUAN_BITWIDTH] ? '1 : w_div_quo_nx[QUAN_BITWIDTH-1:0];

    assign y_recip  = r_y_recip;
    assign uv_recip = r_uv_recip;
`else
    assign y_recip  = '0;
    assign uv_recip = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_h    <= 8'd0;
            r_rem      <= 16'd0;
            r_tq       <= 1'b0;
            r_idx      <= 6'd0;
            r_loaded   <= 2'b00;
            r_y_table  <= '0;
            r_uv_table <= '0;
            r_y_valid  <= 1'b0;
            r_uv_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
`ifdef DQT_PARSER_RECIP_EN
            r_div_tbl  <= 1'b0;
            r_div_idx  <= 6'd0;
            r_div_bit  <= '0;
            r_div_rem  <= 9'd0;
            r_div_quo  <= '0;
            r_y_recip  <= '0;
            r_uv_recip <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc && s_data == 8'hFF) r_state <= S_FF1;
                end
                S_FF1: begin
                    if (w_acc) begin
                        if (s_data == 8'hDB)      r_state <= S_LEN_H;
                        else if (s_data != 8'hFF) r_state <= S_IDLE;
                    end
                end
                S_LEN_H: begin
                    if (w_acc) begin
                        r_len_h <= s_data;
                        r_state <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (w_acc) begin
                        if (w_len_bad) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_rem    <= w_lq_m2;
                            r_loaded <= 2'b00;
                            r_state  <= S_PQTQ;
                        end
                    end
                end
                S_PQTQ: begin
                    if (w_acc) begin
                        if (w_pqtq_bad) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tq  <= s_data[0];
                            r_idx <= 6'd0;
                            r_rem <= r_rem - 16'd1;
                            if (s_data[0]) begin
                                r_uv_valid  <= 1'b0;
                                r_loaded[1] <= 1'b1;
                            end else begin
                                r_y_valid   <= 1'b0;
                                r_loaded[0] <= 1'b1;
                            end
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        if (s_data == 8'd0) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd3;
                            r_state    <= S_IDLE;
                        end else begin
                            if (r_tq) r_uv_table[r_idx[5:3]][r_idx[2:0]] <= s_data;
                            else      r_y_table[r_idx[5:3]][r_idx[2:0]]  <= s_data;
                            r_idx <= r_idx + 6'd1;
                            r_rem <= r_rem - 16'd1;
                            if (r_idx == 6'd63) begin
                                if (r_rem == 16'd1) begin
`ifdef DQT_PARSER_RECIP_EN
                                    r_div_tbl <= ~r_loaded[0];
                                    r_div_idx <= 6'd0;
                                    r_div_bit <= '0;
                                    r_div_rem <= 9'd0;
                                    r_div_quo <= '0;
                                    r_state   <= S_RECIP;
`else
                                    r_state   <= S_DONE;
`endif
                                end else begin
                                    r_state <= S_PQTQ;
                                end
                            end
                        end
                    end
                end
                S_RECIP: begin
`ifdef DQT_PARSER_RECIP_EN
                    if (r_div_bit == c_LAST_BIT) begin
                        if (r_div_tbl) r_uv_recip[r_div_idx[5:3]][r_div_idx[2:0]] <= w_div_res;
                        else           r_y_recip[r_div_idx[5:3]][r_div_idx[2:0]]  <= w_div_res;
                        r_div_bit <= '0;
                        r_div_rem <= 9'd0;
                        r_div_quo <= '0;
                        r_div_idx <= r_div_idx + 6'd1;
                        if (r_div_idx == 6'd63) begin
                            if (!r_div_tbl && r_loaded[1]) r_div_tbl <= 1'b1;
                            else                           r_state   <= S_DONE;
                        end
                    end else begin
                        r_div_rem <= w_div_rem_nx;
                        r_div_quo <= w_div_quo_nx;
                        r_div_bit <= r_div_bit + 1'b1;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (r_loaded[0]) r_y_valid  <= 1'b1;
                    if (r_loaded[1]) r_uv_valid <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign y_table  = r_y_table;
    assign uv_table = r_uv_table;
    assign y_valid  = r_y_valid;
    assign uv_valid = r_uv_valid;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_dqt_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dqt_parser                                                   |
// | Purpose  : Directed self-checking bench for dqt_parser.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dqt_parser;

    localparam int c_MCU = 8;
    localparam int c_QW  = 12;

    logic clk;
    logic rst;
    logic [7:0] s_data;
    logic s_valid;
    logic s_ready;
    logic [c_MCU-1:0][c_MCU-1:0][7:0]      y_table;
    logic [c_MCU-1:0][c_MCU-1:0][7:0]      uv_table;
    logic [c_MCU-1:0][c_MCU-1:0][c_QW-1:0] y_recip;
    logic [c_MCU-1:0][c_MCU-1:0][c_QW-1:0] uv_recip;
    logic y_valid;
    logic uv_valid;
    logic done;
    logic err;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] luma   [64];
    logic [7:0] chroma [64];
    logic [7:0] ramp   [64];

    dqt_parser #(.MCU_SIZE(c_MCU), .QUAN_BITWIDTH(c_QW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .y_table  (y_table),
        .uv_table (uv_table),
        .y_recip  (y_recip),
        .uv_recip (uv_recip),
        .y_valid  (y_valid),
        .uv_valid (uv_valid),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int ntab);
`ifdef DQT_PARSER_RECIP_EN
        return 1 + ntab * 64 * (c_QW + 1);
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] exp_recip(input logic [31:0] with_div);
`ifdef DQT_PARSER_RECIP_EN
        return with_div;
`else
        return 32'd0;
`endif
    endfunction

    // Returns #1 after the edge that accepted the byte
    task automatic send(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 4000) begin @(posedge clk); #1; n++; end
        if (n >= 4000) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout observed=s_ready_low expected=s_ready_high");
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_tbl(input logic [7:0] t [64], input int count, input bit gaps);
        for (int i = 0; i < count; i++) send(t[i], gaps);
    endtask

    task automatic wait_done(input string tag, input int ntab);
        int cyc = 0;
        check({tag, "_ready_low"}, 32'(s_ready), 32'd0);
        while (done !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat(ntab)));
    endtask

    initial begin
        luma = '{16, 11, 10, 16, 24, 40, 51, 61,
                 12, 12, 14, 19, 26, 58, 60, 55,
                 14, 13, 16, 24, 40, 57, 69, 56,
                 14, 17, 22, 29, 51, 87, 80, 62,
                 18, 22, 37, 56, 68, 109, 103, 77,
                 24, 35, 55, 64, 81, 104, 113, 92,
                 49, 64, 78, 87, 103, 121, 120, 101,
                 72, 92, 95, 98, 112, 100, 103, 99};
        for (int i = 0; i < 64; i++) begin
            chroma[i] = 8'd99;
            ramp[i]   = 8'(i + 1);
        end
        chroma[0]  = 17; chroma[1]  = 18; chroma[2]  = 24; chroma[3]  = 47;
        chroma[8]  = 18; chroma[9]  = 21; chroma[10] = 26; chroma[11] = 66;
        chroma[16] = 24; chroma[17] = 26; chroma[18] = 56;
        chroma[24] = 47; chroma[25] = 66;

        // Reset state
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_valids", {30'd0, y_valid, uv_valid}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_tables", 32'((y_table == '0) && (uv_table == '0)), 32'd1);

        // Standard two-table segment
        send(8'hFF, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h84, 0);
        send(8'h00, 0); send_tbl(luma, 64, 0);
        send(8'h01, 0); send_tbl(chroma, 64, 0);
        wait_done("std", 2);
        check("std_valids", {30'd0, y_valid, uv_valid}, 32'd3);
        check("std_err", 32'(err), 32'd0);
        check("std_y00", 32'(y_table[0][0]), 32'd16);
        check("std_y45", 32'(y_table[4][5]), 32'd109);
        check("std_uv77", 32'(uv_table[7][7]), 32'd99);
        check("std_uv13", 32'(uv_table[1][3]), 32'd66);
        check("std_yrecip00", 32'(y_recip[0][0]), exp_recip(32'd256));
        check("std_uvrecip00", 32'(uv_recip[0][0]), exp_recip(32'd240));
        check("std_yrecip77", 32'(y_recip[7][7]), exp_recip(32'd41));
        @(posedge clk); #1;
        check("std_done_pulse", 32'(done), 32'd0);
        check("std_ready_back", 32'(s_ready), 32'd1);

        // Leading junk, then single chroma table
        send(8'h12, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hDB, 0);
        send(8'h00, 0); send(8'h43, 0); send(8'h01, 0);
        check("single_uv_cleared", {30'd0, y_valid, uv_valid}, 32'd2);
        send_tbl(ramp, 64, 0);
        wait_done("single", 1);
        check("single_valids", {30'd0, y_valid, uv_valid}, 32'd3);
        check("single_uv00", 32'(uv_table[0][0]), 32'd1);
        check("single_uv77", 32'(uv_table[7][7]), 32'd64);
        check("single_y_kept", 32'(y_table[0][1]), 32'd11);
        check("single_uvrecip00", 32'(uv_recip[0][0]), exp_recip(32'hFFF));
        check("single_uvrecip77", 32'(uv_recip[7][7]), exp_recip(32'd64));
        check("single_yrecip_kept", 32'(y_recip[0][0]), exp_recip(32'd256));

        // FF followed by a non-marker byte drops back to IDLE
        send(8'hFF, 0); send(8'hA0, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h50, 0);
        check("ff_a0_no_err", {30'd0, err, done}, 32'd0);
        check("ff_a0_code", 32'(err_code), 32'd0);

        // Bad length
        send(8'hFF, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h50, 0);
        check("len50_err", 32'(err), 32'd1);
        check("len50_code", 32'(err_code), 32'd1);
        check("len50_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        check("len50_err_pulse", 32'(err), 32'd0);
        check("len50_code_held", 32'(err_code), 32'd1);
        send(8'hFF, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h02, 0);
        check("len02_err", {30'd0, err, err_code[0]}, 32'd3);

        // Bad Pq/Tq
        send(8'hFF, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h43, 0); send(8'h12, 0);
        check("pqtq12_err", 32'(err), 32'd1);
        check("pqtq12_code", 32'(err_code), 32'd2);
        send(8'hFF, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h43, 0); send(8'h02, 0);
        check("pqtq02_code", {29'd0, err, err_code}, 32'd6);

        // Zero entry at index 5
        send(8'hFF, 0); send(8'hDB, 0); send(8'h00, 0); send(8'h43, 0); send(8'h00, 0);
        send_tbl(luma, 5, 0); send(8'h00, 0);
        check("zero_err", 32'(err), 32'd1);
        check("zero_code", 32'(err_code), 32'd3);
        check("zero_valids", {30'd0, y_valid, uv_valid}, 32'd1);
        @(posedge clk); #1;
        check("zero_no_done", 32'(done), 32'd0);

        // Reset mid-segment with stalls
        send(8'hFF, 1); send(8'hDB, 1); send(8'h00, 1); send(8'h84, 1);
        send(8'h00, 1); send_tbl(luma, 30, 1);
        rst = 1'b1;
        #2;
        check("mrst_ready", 32'(s_ready), 32'd1);
        check("mrst_flags", {28'd0, y_valid, uv_valid, done, err}, 32'd0);
        check("mrst_code", 32'(err_code), 32'd0);
        check("mrst_tables", 32'((y_table == '0) && (uv_table == '0)), 32'd1);
        check("mrst_recips", 32'((y_recip == '0) && (uv_recip == '0)), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_no_pulse", {30'd0, done, err}, 32'd0);

        // Full segment after reset, with stalls and a q=1 entry
        send(8'hFF, 1); send(8'hDB, 1); send(8'h00, 1); send(8'h84, 1);
        send(8'h00, 1); send_tbl(luma, 64, 1);
        send(8'h01, 1); send_tbl(ramp, 64, 1);
        wait_done("post", 2);
        check("post_valids", {30'd0, y_valid, uv_valid}, 32'd3);
        check("post_y77", 32'(y_table[7][7]), 32'd99);
        check("post_uv00", 32'(uv_table[0][0]), 32'd1);
        check("post_uv23", 32'(uv_table[2][3]), 32'd20);
        check("post_uvrecip00", 32'(uv_recip[0][0]), exp_recip(32'hFFF));
        check("post_yrecip01", 32'(y_recip[0][1]), exp_recip(32'd372));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
